// File: rtl/bsa_pkg.sv
// Shared definitions for the byte-serial adder: byte width, FSM state encoding
// and the index-width helper.
package bsa_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never fewer than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/byte_serial_adder_csa8.sv
// 8-bit carry-select adder: low nibble ripples, high nibble is computed for
// both carry values and selected by the low-nibble carry.
module csa8
    import bsa_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    always_comb begin
        lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        sum[3:0] = lo[3:0];
        {cout, sum[7:4]} = lo[4] ? hi1 : hi0;
    end

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder that streams operands through one csa8, one byte per clock, LSB first.
// Optional subtract mode (sub port, B inverted, carry-in forced to 1) under `define BSA_SUB_EN.
module byte_serial_adder
    import bsa_pkg::*;
#(
    parameter  int BYTES = 4,
    localparam int W     = BYTE_W * BYTES
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef BSA_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int                IDX_W    = clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               c_q, c_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
    logic               sub_sel;
    logic [IDX_W+2:0]   base;
    logic [BYTE_W-1:0]  a_byte, b_byte, byte_sum;
    logic               byte_cout;

`ifdef BSA_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Byte mux: bit offset of the current byte is idx*8.
    assign base   = {idx_q, 3'b000};
    assign a_byte = a_q[base +: BYTE_W];
    assign b_byte = b_q[base +: BYTE_W];

    csa8 u_csa8 (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (c_q),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                sum_d[base +: BYTE_W] = byte_sum;
                c_d   = byte_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = byte_cout;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    a_d     = a;
                    b_d     = sub_sel ? ~b : b;
                    c_d     = sub_sel | cin;
                    idx_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operand holding registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/byte_serial_adder.md
# byte_serial_adder

Multi-cycle wide-operand adder that streams BYTES-byte operands through one 8-bit carry-select adder core, one byte per clock, least-significant byte first. The carry is held in a flip-flop between bytes. The block sits directly upstream of the CSA8 core: it sequences operand bytes into it and consumes its sum and carry-out. A start/busy/done handshake lets a controller launch additions wider than 8 bits without replicating adder hardware.

## Interface
- BYTES, 4, operand width in bytes; legal range 1..16; W = 8*BYTES.
- clk  in  1  rising-edge clock (single clock domain).
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  launch request; sampled only when busy=0.
- a  in  W  operand A; captured on the accepted start edge.
- b  in  W  operand B; captured on the accepted start edge.
- cin  in  1  carry-in to byte 0; captured with the operands.
- sub  in  1  subtract select; present only when BSA_SUB_EN is defined.
- busy  out  1  high while bytes are being processed.
- done  out  1  one-cycle pulse; sum and cout are valid.
- sum  out  W  result register; holds its value until overwritten.
- cout  out  1  final carry-out of the most significant byte.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE, start=1: capture a, b and the initial carry into a_q, b_q, c_q. Clear byte index idx to 0. Go to RUN.
- IDLE or DONE, start=0: go to IDLE (DONE always lasts one cycle).
- RUN, each cycle:
  - Adder inputs are a_q[8*idx+:8], b_q[8*idx+:8] and c_q.
  - The 8-bit result is written to sum[8*idx+:8]; the adder carry-out is written to c_q; idx increments.
  - When idx = BYTES-1, the same edge also loads cout with the adder carry-out and moves the FSM to DONE.
- start while busy=1 is ignored. Operands, state and result are unaffected.
- sum is not cleared on start. Bytes above idx keep stale data until they are overwritten. sum and cout are defined only from done onward, until the next accepted start.
- BYTES=1: RUN lasts exactly one cycle.
- All arithmetic is modulo 2^W. cout is the carry out of bit W-1.
- Reset values: busy=0, done=0, sum=0, cout=0, c_q=0, idx=0, state IDLE.
- rst_n low mid-operation aborts immediately, asynchronously. No done pulse follows.

## Timing
- E0 is the rising edge at which start is accepted.
- busy is high during the cycles after edges E0 .. E0+BYTES-1.
- Byte k is written at edge E0+1+k, for k = 0..BYTES-1.
- Edge E0+BYTES:
  - the final byte is written;
  - cout is updated;
  - done rises; busy falls.
- done stays high for exactly one cycle.
- Latency from E0 to done is BYTES cycles. This is BYTES+1 edges between consecutive accepted starts, including the DONE cycle.
- A start held high during DONE is accepted on that edge (back-to-back). busy goes high again the following cycle.
- busy and done are never high together.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- BSA_SUB_EN defined:
  - the sub port exists and is captured with the operands;
  - sub=1 stores b_q as the bitwise inverse of b and forces the initial c_q to 1, ignoring cin. The result is A-B;
  - cout=1 means no borrow; cout=0 means borrow.
- BSA_SUB_EN undefined:
  - there is no sub port;
  - b is captured unmodified and the initial c_q is cin.

## Structure
- Shared package bsa_pkg holds:
  - BYTE_W = 8;
  - the state enum {IDLE, RUN, DONE};
  - the function clog2 used to size idx (minimum 1 bit).
- One sub-module: CSA8, the existing 8-bit carry-select adder. It is instantiated once and fed from the byte mux; its sum and cout are registered here.
- The FSM, capture registers, byte mux and result write-back all live in byte_serial_adder.

## Test plan
All scenarios use BYTES=4.
1. a=0x000000FF, b=0x00000001, cin=0, start pulse -> busy for 4 cycles, done at E0+4, sum=0x00000100, cout=0.
2. a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1; carry ripples through all 4 bytes.
3. With BSA_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0. Then a=7, b=5 -> sum=0x00000002, cout=1.
4. Launch a=0x12345678, b=0x11111111. Pulse start at E0+2 with a=b=0xFFFFFFFF -> second start ignored; sum=0x23456789, cout=0; exactly one done.
5. Drop rst_n between E0+1 and E0+2 -> busy=0, done=0, sum=0, cout=0 immediately. After release, a=1, b=1 -> sum=2, done at its E0+4.
6. Hold start high with new operands a=0x80000000, b=0x80000000 during the DONE cycle -> accepted back-to-back; next done yields sum=0x00000000, cout=1.
